psychic5_sdram_arbiter: RTL and testbench

PSYCHIC5_SDRAM_ARBITER -- requirements
Module: psychic5_sdram_arbiter

---
 rtl/psychic5_sdram_arbiter_if.sv | 34 +++
 rtl/psychic5_sdram_arbiter.sv | 109 ++++++++++
 tb/tb_psychic5_sdram_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/psychic5_sdram_arbiter_if.sv
// Bus bundle between the Psychic 5 ROM clients, the arbiter and the SDRAM controller.
// Handshake: o_SDRAM_RD is a level request; it and o_SDRAM_ADDR stay stable until a one-cycle i_SDRAM_ACK carries i_SDRAM_DATA. Client RQ_n is an active-low level request and READY means DATA belongs to the current ADDR.
interface psychic5_sdram_arbiter_if;
  logic [16:0] i_EMU_MAINCPU_ADDR;
  logic        i_EMU_MAINCPU_RQ_n;
  logic [7:0]  o_EMU_MAINCPU_DATA;
  logic        o_EMU_MAINCPU_READY;
  logic [16:0] i_EMU_OBJROM_ADDR;
  logic        i_EMU_OBJROM_RQ_n;
  logic [7:0]  o_EMU_OBJROM_DATA;
  logic        o_EMU_OBJROM_READY;
  logic [24:0] o_SDRAM_ADDR;
  logic        o_SDRAM_RD;
  logic        i_SDRAM_ACK;
  logic [7:0]  i_SDRAM_DATA;

  modport slave (
    input  i_EMU_MAINCPU_ADDR, i_EMU_MAINCPU_RQ_n,
    input  i_EMU_OBJROM_ADDR, i_EMU_OBJROM_RQ_n,
    input  i_SDRAM_ACK, i_SDRAM_DATA,
    output o_EMU_MAINCPU_DATA, o_EMU_MAINCPU_READY,
    output o_EMU_OBJROM_DATA, o_EMU_OBJROM_READY,
    output o_SDRAM_ADDR, o_SDRAM_RD
  );

  modport master (
    output i_EMU_MAINCPU_ADDR, i_EMU_MAINCPU_RQ_n,
    output i_EMU_OBJROM_ADDR, i_EMU_OBJROM_RQ_n,
    output i_SDRAM_ACK, i_SDRAM_DATA,
    input  o_EMU_MAINCPU_DATA, o_EMU_MAINCPU_READY,
    input  o_EMU_OBJROM_DATA, o_EMU_OBJROM_READY,
    input  o_SDRAM_ADDR, o_SDRAM_RD
  );
endinterface

// File: rtl/psychic5_sdram_arbiter.sv
// Two-port SDRAM read arbiter with a one-entry byte cache per port and
// round-robin tie breaking between the main CPU and object ROM fetchers.
module psychic5_sdram_arbiter #(
  parameter logic [24:0] MAINCPU_BASE = 25'h0000000,
  parameter logic [24:0] OBJROM_BASE  = 25'h0020000
) (
  input  logic                           i_EMU_MCLK,
  input  logic                           i_EMU_INITRST,
  psychic5_sdram_arbiter_if.slave        bus,
  output logic [1:0]                     state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, CPU_RD = 2'd1, OBJ_RD = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [16:0] cpu_tag, obj_tag, lat_addr;
  logic        cpu_valid, obj_valid;
  logic [7:0]  cpu_data, obj_data;
  logic        last_obj;
  logic        sdram_rd;
  logic [24:0] sdram_addr;
  logic        cpu_hit, obj_hit, cpu_pend, obj_pend;
  logic        grant_cpu, grant_obj, fill;

  assign cpu_hit  = !bus.i_EMU_MAINCPU_RQ_n && cpu_valid && (bus.i_EMU_MAINCPU_ADDR == cpu_tag);
  assign obj_hit  = !bus.i_EMU_OBJROM_RQ_n && obj_valid && (bus.i_EMU_OBJROM_ADDR == obj_tag);
  assign cpu_pend = !bus.i_EMU_MAINCPU_RQ_n && !cpu_hit;
  assign obj_pend = !bus.i_EMU_OBJROM_RQ_n && !obj_hit;

  assign bus.o_EMU_MAINCPU_READY = cpu_hit;
  assign bus.o_EMU_OBJROM_READY  = obj_hit;
  assign bus.o_EMU_MAINCPU_DATA  = cpu_data;
  assign bus.o_EMU_OBJROM_DATA   = obj_data;
  assign bus.o_SDRAM_RD          = sdram_rd;
  assign bus.o_SDRAM_ADDR        = sdram_addr;
  assign state_dbg               = state;

  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_INITRST) state <= IDLE;
    else               state <= state_nxt;
  end

  // On a tie the port that did not win last time is granted.
  always_comb begin
    state_nxt = state;
    grant_cpu = 1'b0;
    grant_obj = 1'b0;
    fill      = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_pend && (!obj_pend || last_obj)) begin
          grant_cpu = 1'b1;
          state_nxt = CPU_RD;
        end else if (obj_pend) begin
          grant_obj = 1'b1;
          state_nxt = OBJ_RD;
        end
      end
      CPU_RD, OBJ_RD: begin
        if (bus.i_SDRAM_ACK) begin
          fill      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_INITRST) begin
      cpu_tag    <= '0;
      obj_tag    <= '0;
      cpu_valid  <= 1'b0;
      obj_valid  <= 1'b0;
      cpu_data   <= '0;
      obj_data   <= '0;
      lat_addr   <= '0;
      last_obj   <= 1'b1;
      sdram_rd   <= 1'b0;
      sdram_addr <= '0;
    end else begin
      if (grant_cpu) begin
        lat_addr   <= bus.i_EMU_MAINCPU_ADDR;
        sdram_addr <= MAINCPU_BASE + {8'b0, bus.i_EMU_MAINCPU_ADDR};
        sdram_rd   <= 1'b1;
        last_obj   <= 1'b0;
      end else if (grant_obj) begin
        lat_addr   <= bus.i_EMU_OBJROM_ADDR;
        sdram_addr <= OBJROM_BASE + {8'b0, bus.i_EMU_OBJROM_ADDR};
        sdram_rd   <= 1'b1;
        last_obj   <= 1'b1;
      end
      // The tag takes the latched address, even if the client moved on mid-read.
      if (fill) begin
        sdram_rd <= 1'b0;
        if (state == CPU_RD) begin
          cpu_data  <= bus.i_SDRAM_DATA;
          cpu_tag   <= lat_addr;
          cpu_valid <= 1'b1;
        end else begin
          obj_data  <= bus.i_SDRAM_DATA;
          obj_tag   <= lat_addr;
          obj_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_psychic5_sdram_arbiter.sv
// Bench for psychic5_sdram_arbiter: directed vector table, a wrap-around case
// on a second instance, and a randomized run against a cache-level model.
module tb_psychic5_sdram_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  psychic5_sdram_arbiter_if bus();
  psychic5_sdram_arbiter_if wbus();
  logic [1:0] state_dbg, wstate_dbg;

  psychic5_sdram_arbiter u_dut (
    .i_EMU_MCLK(clk), .i_EMU_INITRST(rst), .bus(bus), .state_dbg(state_dbg)
  );

  psychic5_sdram_arbiter #(.OBJROM_BASE(25'h1FFFFFF)) u_wrap (
    .i_EMU_MCLK(clk), .i_EMU_INITRST(rst), .bus(wbus), .state_dbg(wstate_dbg)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [16:0] ca;
    logic        crq;
    logic [16:0] oa;
    logic        orq;
    logic        ack;
    logic [7:0]  ad;
    logic        erd;
    logic [24:0] eaddr;
    logic        chka;
    logic        ecr;
    logic [7:0]  ecd;
    logic        eor;
    logic [7:0]  eod;
  } vec_t;

  vec_t tbl[30];

  // Scoreboard of expected SDRAM read addresses from the random-phase model.
  logic [24:0] exp_q[$];

  localparam logic [31:0] CPU_BASE = 32'h0000000;
  localparam logic [31:0] OBJ_BASE = 32'h0020000;

  logic [16:0] m_tag[2];
  logic        m_valid[2];
  logic [7:0]  m_data[2];
  logic        m_busy, m_port, m_last_obj, m_new;
  logic [16:0] m_addr;
  logic [24:0] cur_addr;
  logic [16:0] pool[4];
  int          cnt;

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_tag[p] = '0; m_valid[p] = 1'b0; m_data[p] = '0;
    end
    m_busy = 1'b0; m_port = 1'b0; m_last_obj = 1'b1; m_new = 1'b0;
    m_addr = '0; cur_addr = '0; cnt = 0;
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    bus.i_EMU_MAINCPU_ADDR = '0; bus.i_EMU_MAINCPU_RQ_n = 1'b1;
    bus.i_EMU_OBJROM_ADDR  = '0; bus.i_EMU_OBJROM_RQ_n  = 1'b1;
    bus.i_SDRAM_ACK = 1'b0; bus.i_SDRAM_DATA = '0;
    wbus.i_EMU_MAINCPU_ADDR = '0; wbus.i_EMU_MAINCPU_RQ_n = 1'b1;
    wbus.i_EMU_OBJROM_ADDR  = '0; wbus.i_EMU_OBJROM_RQ_n  = 1'b1;
    wbus.i_SDRAM_ACK = 1'b0; wbus.i_SDRAM_DATA = '0;

    //            rst  ca         crq  oa         orq  ack  ad     erd  eaddr          chka ecr  ecd    eor  eod
    tbl[0]  = '{1'b0, 17'h00123, 1'b1, 17'h00000, 1'b1, 1'b0, 8'h00, 1'b0, 25'h0000000, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 17'h00123, 1'b0, 17'h00000, 1'b1, 1'b0, 8'h00, 1'b0, 25'h0000000, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 17'h00123, 1'b0, 17'h00000, 1'b1, 1'b0, 8'h00, 1'b1, 25'h0000123, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 17'h00123, 1'b0, 17'h00000, 1'b1, 1'b0, 8'h00, 1'b1, 25'h0000123, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[4]  = '{1'b0, 17'h00123, 1'b0, 17'h00000, 1'b1, 1'b1, 8'hA5, 1'b1, 25'h0000123, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[5]  = '{1'b0, 17'h00123, 1'b0, 17'h00000, 1'b1, 1'b0, 8'h00, 1'b0, 25'h0000000, 1'b0, 1'b1, 8'hA5, 1'b0, 8'h00};
    tbl[6]  = '{1'b0, 17'h00123, 1'b1, 17'h00000, 1'b1, 1'b0, 8'h00, 1'b0, 25'h0000000, 1'b0, 1'b0, 8'hA5, 1'b0, 8'h00};
    tbl[7]  = '{1'b0, 17'h00123, 1'b0, 17'h00000, 1'b1, 1'b0, 8'h00, 1'b0, 25'h0000000, 1'b0, 1'b1, 8'hA5, 1'b0, 8'h00};
    tbl[8]  = '{1'b0, 17'h00123, 1'b0, 17'h00000, 1'b1, 1'b0, 8'h00, 1'b0, 25'h0000000, 1'b0, 1'b1, 8'hA5, 1'b0, 8'h00};
    tbl[9]  = '{1'b1, 17'h00123, 1'b1, 17'h00000, 1'b1, 1'b0, 8'h00, 1'b0, 25'h0000000, 1'b0, 1'b0, 8'hA5, 1'b0, 8'h00};
    tbl[10] = '{1'b0, 17'h00123, 1'b1, 17'h00000, 1'b1, 1'b0, 8'h00, 1'b0, 25'h0000000, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[11] = '{1'b0, 17'h00055, 1'b0, 17'h00AAA, 1'b0, 1'b0, 8'h00, 1'b0, 25'h0000000, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[12] = '{1'b0, 17'h00055, 1'b0, 17'h00AAA, 1'b0, 1'b0, 8'h00, 1'b1, 25'h0000055, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[13] = '{1'b0, 17'h00055, 1'b0, 17'h00AAA, 1'b0, 1'b1, 8'h11, 1'b1, 25'h0000055, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[14] = '{1'b0, 17'h00066, 1'b0, 17'h00AAA, 1'b0, 1'b0, 8'h00, 1'b0, 25'h0000000, 1'b0, 1'b0, 8'h11, 1'b0, 8'h00};
    tbl[15] = '{1'b0, 17'h00066, 1'b0, 17'h00AAA, 1'b0, 1'b0, 8'h00, 1'b1, 25'h0020AAA, 1'b1, 1'b0, 8'h11, 1'b0, 8'h00};
    tbl[16] = '{1'b0, 17'h00066, 1'b0, 17'h00AAA, 1'b0, 1'b1, 8'h22, 1'b1, 25'h0020AAA, 1'b1, 1'b0, 8'h11, 1'b0, 8'h00};
    tbl[17] = '{1'b0, 17'h00066, 1'b0, 17'h00AAA, 1'b0, 1'b0, 8'h00, 1'b0, 25'h0000000, 1'b0, 1'b0, 8'h11, 1'b1, 8'h22};
    tbl[18] = '{1'b0, 17'h00066, 1'b0, 17'h00AAA, 1'b0, 1'b0, 8'h00, 1'b1, 25'h0000066, 1'b1, 1'b0, 8'h11, 1'b1, 8'h22};
    tbl[19] = '{1'b0, 17'h00066, 1'b0, 17'h00AAA, 1'b0, 1'b1, 8'h33, 1'b1, 25'h0000066, 1'b1, 1'b0, 8'h11, 1'b1, 8'h22};
    tbl[20] = '{1'b0, 17'h00066, 1'b0, 17'h00AAA, 1'b0, 1'b0, 8'h00, 1'b0, 25'h0000000, 1'b0, 1'b1, 8'h33, 1'b1, 8'h22};
    tbl[21] = '{1'b0, 17'h00066, 1'b1, 17'h1FFFF, 1'b0, 1'b0, 8'h00, 1'b0, 25'h0000000, 1'b0, 1'b0, 8'h33, 1'b0, 8'h22};
    tbl[22] = '{1'b0, 17'h00066, 1'b1, 17'h1FFFF, 1'b0, 1'b0, 8'h00, 1'b1, 25'h003FFFF, 1'b1, 1'b0, 8'h33, 1'b0, 8'h22};
    tbl[23] = '{1'b0, 17'h00066, 1'b1, 17'h00010, 1'b0, 1'b0, 8'h00, 1'b1, 25'h003FFFF, 1'b1, 1'b0, 8'h33, 1'b0, 8'h22};
    tbl[24] = '{1'b0, 17'h00066, 1'b1, 17'h00010, 1'b0, 1'b1, 8'h44, 1'b1, 25'h003FFFF, 1'b1, 1'b0, 8'h33, 1'b0, 8'h22};
    tbl[25] = '{1'b0, 17'h00066, 1'b1, 17'h00010, 1'b0, 1'b0, 8'h00, 1'b0, 25'h0000000, 1'b0, 1'b0, 8'h33, 1'b0, 8'h44};
    tbl[26] = '{1'b0, 17'h00066, 1'b1, 17'h00010, 1'b0, 1'b0, 8'h00, 1'b1, 25'h0020010, 1'b1, 1'b0, 8'h33, 1'b0, 8'h44};
    tbl[27] = '{1'b1, 17'h00066, 1'b1, 17'h00010, 1'b0, 1'b0, 8'h00, 1'b1, 25'h0020010, 1'b1, 1'b0, 8'h33, 1'b0, 8'h44};
    tbl[28] = '{1'b0, 17'h00066, 1'b1, 17'h00010, 1'b1, 1'b1, 8'h55, 1'b0, 25'h0000000, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[29] = '{1'b0, 17'h00066, 1'b1, 17'h00010, 1'b0, 1'b0, 8'h00, 1'b0, 25'h0000000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};

    repeat (2) @(posedge clk);

    // Directed vectors: inputs applied at negedge, outputs checked before the next rising edge.
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      rst = tbl[i].rst;
      bus.i_EMU_MAINCPU_ADDR = tbl[i].ca; bus.i_EMU_MAINCPU_RQ_n = tbl[i].crq;
      bus.i_EMU_OBJROM_ADDR  = tbl[i].oa; bus.i_EMU_OBJROM_RQ_n  = tbl[i].orq;
      bus.i_SDRAM_ACK = tbl[i].ack; bus.i_SDRAM_DATA = tbl[i].ad;
      #1;
      check($sformatf("row%0d_sdram_rd", i), 32'(bus.o_SDRAM_RD), 32'(tbl[i].erd));
      if (tbl[i].chka)
        check($sformatf("row%0d_sdram_addr", i), 32'(bus.o_SDRAM_ADDR), 32'(tbl[i].eaddr));
      check($sformatf("row%0d_cpu_ready", i), 32'(bus.o_EMU_MAINCPU_READY), 32'(tbl[i].ecr));
      check($sformatf("row%0d_cpu_data", i), 32'(bus.o_EMU_MAINCPU_DATA), 32'(tbl[i].ecd));
      check($sformatf("row%0d_obj_ready", i), 32'(bus.o_EMU_OBJROM_READY), 32'(tbl[i].eor));
      check($sformatf("row%0d_obj_data", i), 32'(bus.o_EMU_OBJROM_DATA), 32'(tbl[i].eod));
    end

    // Wrap-around of base + address on the second instance.
    @(negedge clk);
    bus.i_EMU_MAINCPU_RQ_n = 1'b1; bus.i_EMU_OBJROM_RQ_n = 1'b1; bus.i_SDRAM_ACK = 1'b0;
    wbus.i_EMU_OBJROM_ADDR = 17'h00002; wbus.i_EMU_OBJROM_RQ_n = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (wbus.o_SDRAM_RD) break;
    end
    check("wrap_rd", 32'(wbus.o_SDRAM_RD), 32'd1);
    check("wrap_addr", 32'(wbus.o_SDRAM_ADDR), 32'h0000001);
    @(negedge clk);
    wbus.i_SDRAM_ACK = 1'b1; wbus.i_SDRAM_DATA = 8'h77;
    @(negedge clk);
    wbus.i_SDRAM_ACK = 1'b0;
    #1;
    check("wrap_ready", 32'(wbus.o_EMU_OBJROM_READY), 32'd1);
    check("wrap_data", 32'(wbus.o_EMU_OBJROM_DATA), 32'h77);
    check("wrap_rd_drop", 32'(wbus.o_SDRAM_RD), 32'd0);
    wbus.i_EMU_OBJROM_RQ_n = 1'b1;

    // Randomized phase against the cache-level model.
    pool[0] = 17'h00000; pool[1] = 17'h00001; pool[2] = 17'h1FFFF; pool[3] = 17'h0ABCD;
    @(negedge clk);
    rst = 1'b1;
    bus.i_EMU_MAINCPU_RQ_n = 1'b1; bus.i_EMU_OBJROM_RQ_n = 1'b1; bus.i_SDRAM_ACK = 1'b0;
    @(posedge clk);
    model_reset();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [16:0] a[2];
      logic        rq_n[2], hit[2], pend[2];
      logic        port;
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) bus.i_EMU_MAINCPU_ADDR = pool[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) bus.i_EMU_OBJROM_ADDR  = pool[$urandom_range(0, 3)];
      bus.i_EMU_MAINCPU_RQ_n = ($urandom_range(0, 4) == 0);
      bus.i_EMU_OBJROM_RQ_n  = ($urandom_range(0, 4) == 0);
      if (m_busy) bus.i_SDRAM_ACK = (cnt == 0);
      else        bus.i_SDRAM_ACK = ($urandom_range(0, 7) == 0);
      bus.i_SDRAM_DATA = 8'($urandom);
      #1;
      a[0] = bus.i_EMU_MAINCPU_ADDR; rq_n[0] = bus.i_EMU_MAINCPU_RQ_n;
      a[1] = bus.i_EMU_OBJROM_ADDR;  rq_n[1] = bus.i_EMU_OBJROM_RQ_n;
      for (int p = 0; p < 2; p++) begin
        hit[p]  = !rq_n[p] && m_valid[p] && (a[p] == m_tag[p]);
        pend[p] = !rq_n[p] && !hit[p];
      end
      check("rnd_cpu_ready", 32'(bus.o_EMU_MAINCPU_READY), 32'(hit[0]));
      check("rnd_obj_ready", 32'(bus.o_EMU_OBJROM_READY), 32'(hit[1]));
      check("rnd_cpu_data", 32'(bus.o_EMU_MAINCPU_DATA), 32'(m_data[0]));
      check("rnd_obj_data", 32'(bus.o_EMU_OBJROM_DATA), 32'(m_data[1]));
      check("rnd_sdram_rd", 32'(bus.o_SDRAM_RD), 32'(m_busy));
      if (m_busy) begin
        if (m_new) begin
          cur_addr = exp_q.pop_front();
          m_new = 1'b0;
        end
        check("rnd_sdram_addr", 32'(bus.o_SDRAM_ADDR), 32'(cur_addr));
      end
      // Apply the rising-edge rules to the model.
      if (rst) begin
        model_reset();
      end else if (m_busy) begin
        if (bus.i_SDRAM_ACK) begin
          m_data[m_port] = bus.i_SDRAM_DATA;
          m_tag[m_port] = m_addr;
          m_valid[m_port] = 1'b1;
          m_busy = 1'b0;
        end else begin
          cnt--;
        end
      end else if (pend[0] || pend[1]) begin
        if (pend[0] && pend[1]) port = !m_last_obj;
        else                    port = pend[1];
        m_port = port;
        m_addr = a[port];
        m_busy = 1'b1;
        m_new = 1'b1;
        m_last_obj = port;
        exp_q.push_back(25'(((port ? OBJ_BASE : CPU_BASE) + 32'(a[port])) & 32'h1FFFFFF));
        cnt = $urandom_range(0, 4);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
